instr_fetch: RTL and testbench

Upstream stage of the cpu core. Streams bytecode from a byte-wide synchronous program memory into a small prefetch buffer. Decodes the length of the head instruction and presents op_code/arg1/arg2 to the cpu as one aligned instruction under a valid/ready handshake. Replaces direct pc-indexed memory peeking, so the core sees one complete instruction per accept.

---
 rtl/bali_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch_buf.sv | 63 ++++++
 rtl/instr_fetch.sv | 77 +++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bali_pkg.sv
// Shared bytecode definitions: opcode constants and the instruction-length decoder
// used by both the fetch stage and the cpu decoder.
package bali_pkg;

  localparam logic [7:0] OP_BIPUSH   = 8'h10;
  localparam logic [7:0] OP_SIPUSH   = 8'h11;
  localparam logic [7:0] OP_LDC      = 8'h12;
  localparam logic [7:0] OP_ILOAD    = 8'h15;
  localparam logic [7:0] OP_ISTORE   = 8'h36;
  localparam logic [7:0] OP_IINC     = 8'h84;
  localparam logic [7:0] OP_IF_FIRST = 8'h99;
  localparam logic [7:0] OP_IF_LAST  = 8'hA6;
  localparam logic [7:0] OP_GOTO     = 8'hA7;

  typedef logic [1:0] instr_len_t;

  function automatic instr_len_t instr_len(input logic [7:0] op);
    if (op == OP_BIPUSH || op == OP_LDC || op == OP_ILOAD || op == OP_ISTORE)
      return 2'd2;
    else if (op == OP_SIPUSH || op == OP_IINC || op == OP_GOTO ||
             (op >= OP_IF_FIRST && op <= OP_IF_LAST))
      return 2'd3;
    else
      return 2'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the program-memory read port, the redirect request and the
// instruction valid/ready handshake between fetch stage and cpu.
interface instr_fetch_if #(parameter int ADDR_W = 8);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        op_code;
  logic [7:0]        arg1;
  logic [7:0]        arg2;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_rd, mem_addr, instr_valid, op_code, arg1, arg2, instr_pc,
    input  mem_data, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_rd, mem_addr, instr_valid, op_code, arg1, arg2, instr_pc,
    output mem_data, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_buf.sv
// Byte-wide prefetch shift buffer: pops 0..3 bytes from the head and pushes one
// byte at the tail in the same cycle; exposes the three head bytes.
module fetch_buf #(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic [1:0]       pop_n,
  output logic [CNT_W-1:0] count,
  output logic [7:0]       peek0,
  output logic [7:0]       peek1,
  output logic [7:0]       peek2
);
  localparam int IDX_W = $clog2(BUF_DEPTH);

  logic [7:0]       data_q [BUF_DEPTH];
  logic [7:0]       data_d [BUF_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] src_idx, wr_idx;

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    src_idx = '0;
    wr_idx  = '0;
    if (flush) begin
      count_d = '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (i + int'(pop_n) < BUF_DEPTH) begin
          src_idx   = IDX_W'(i + int'(pop_n));
          data_d[i] = data_q[src_idx];
        end
      end
      // Tail slot after the pop; the issuer never lets count+inflight exceed depth.
      if (push) begin
        wr_idx         = IDX_W'(int'(count_q) - int'(pop_n));
        data_d[wr_idx] = push_data;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign count = count_q;
  // Masking empty slots keeps never-written storage from reaching the decoder.
  assign peek0 = (count_q > CNT_W'(0)) ? data_q[0] : 8'h00;
  assign peek1 = (count_q > CNT_W'(1)) ? data_q[1] : 8'h00;
  assign peek2 = (count_q > CNT_W'(2)) ? data_q[2] : 8'h00;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: streams bytecode into a prefetch buffer and hands the cpu one
// length-decoded instruction per accept, with redirect flush support.
module instr_fetch
  import bali_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              inflight_q, inflight_d;
  logic              run_q, run_d;

  logic [CNT_W-1:0]  count;
  logic [7:0]        peek0, peek1, peek2;
  instr_len_t        head_len;
  logic              valid, accept, mem_rd;
  logic [1:0]        pop_n;

  fetch_buf #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect),
    .push      (inflight_q),
    .push_data (bus.mem_data),
    .pop_n     (pop_n),
    .count     (count),
    .peek0     (peek0),
    .peek1     (peek1),
    .peek2     (peek2)
  );

  always_comb begin
    head_len   = instr_len(peek0);
    valid      = (count >= CNT_W'(head_len));
    // run_q holds off the first read until the cycle after reset is released.
    mem_rd     = run_q && ((int'(count) + int'(inflight_q)) < BUF_DEPTH);
    accept     = valid && bus.instr_ready && !bus.redirect;
    pop_n      = accept ? head_len : 2'd0;
    run_d      = 1'b1;
    // A read issued during a redirect is killed here, so its data is never pushed.
    inflight_d = mem_rd && !bus.redirect;
    fetch_pc_d = bus.redirect ? bus.redirect_pc : fetch_pc_q + ADDR_W'(mem_rd);
    instr_pc_d = instr_pc_q;
    if (bus.redirect)  instr_pc_d = bus.redirect_pc;
    else if (accept)   instr_pc_d = instr_pc_q + ADDR_W'(head_len);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= '0;
      instr_pc_q <= '0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      instr_pc_q <= instr_pc_d;
      inflight_q <= inflight_d;
      run_q      <= run_d;
    end
  end

  assign bus.mem_rd      = mem_rd;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.instr_valid = valid;
  assign bus.op_code     = valid ? peek0 : 8'h00;
  assign bus.arg1        = (valid && head_len >= 2'd2) ? peek1 : 8'h00;
  assign bus.arg2        = (valid && head_len == 2'd3) ? peek2 : 8'h00;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table-driven instruction stream plus
// hand-written stall, redirect, wrap and mid-stream reset sequences.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(8)) bus ();
  instr_fetch #(.ADDR_W(8), .BUF_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [7:0] mem [256];
  always @(posedge clk) bus.mem_data <= bus.mem_rd ? mem[bus.mem_addr] : 8'hEE;

  typedef struct {
    logic [7:0] op;
    logic [7:0] b1;
    logic [7:0] b2;
    int         len;
  } vec_t;
  vec_t vecs [13];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic get_instr(output bit got, output logic [7:0] op, output logic [7:0] a1,
                           output logic [7:0] a2, output logic [7:0] pc);
    got = 1'b0; op = 8'h00; a1 = 8'h00; a2 = 8'h00; pc = 8'h00;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        got = 1'b1;
        op = bus.op_code; a1 = bus.arg1; a2 = bus.arg2; pc = bus.instr_pc;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    bit         got;
    logic [7:0] op, a1, a2, pc, addr, exp_pc;

    vecs[0]  = '{8'h10, 8'h05, 8'h00, 2};  // bipush
    vecs[1]  = '{8'h60, 8'h00, 8'h00, 1};
    vecs[2]  = '{8'h11, 8'h12, 8'h34, 3};  // sipush
    vecs[3]  = '{8'h12, 8'h07, 8'h00, 2};  // ldc
    vecs[4]  = '{8'h15, 8'h03, 8'h00, 2};  // iload
    vecs[5]  = '{8'h36, 8'h04, 8'h00, 2};  // istore
    vecs[6]  = '{8'h84, 8'h01, 8'hFF, 3};  // iinc
    vecs[7]  = '{8'h98, 8'h00, 8'h00, 1};  // just below if* range
    vecs[8]  = '{8'h99, 8'h00, 8'h08, 3};  // first if*
    vecs[9]  = '{8'hA6, 8'hFF, 8'hF0, 3};  // last if*
    vecs[10] = '{8'hA7, 8'h00, 8'h20, 3};  // goto
    vecs[11] = '{8'hA8, 8'h00, 8'h00, 1};  // just above goto
    vecs[12] = '{8'h13, 8'h00, 8'h00, 1};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    addr = 8'h00;
    for (int i = 0; i < 13; i++) begin
      mem[addr] = vecs[i].op;
      if (vecs[i].len >= 2) mem[addr + 8'd1] = vecs[i].b1;
      if (vecs[i].len == 3) mem[addr + 8'd2] = vecs[i].b2;
      addr = addr + 8'(vecs[i].len);
    end

    rst_n = 1'b0; bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 8'h00;
    @(negedge clk); @(negedge clk);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_op", bus.op_code, 0);
    check("rst_arg1", bus.arg1, 0);
    check("rst_arg2", bus.arg2, 0);
    check("rst_pc", bus.instr_pc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_rd", bus.mem_rd, 1);
    check("first_addr", bus.mem_addr, 0);

    // Instruction stream from the table
    bus.instr_ready = 1'b1;
    exp_pc = 8'h00;
    for (int i = 0; i < 13; i++) begin
      get_instr(got, op, a1, a2, pc);
      check("tbl_timeout", got, 1);
      check("tbl_op", op, vecs[i].op);
      check("tbl_arg1", a1, (vecs[i].len >= 2) ? vecs[i].b1 : 8'h00);
      check("tbl_arg2", a2, (vecs[i].len == 3) ? vecs[i].b2 : 8'h00);
      check("tbl_pc", pc, exp_pc);
      exp_pc = exp_pc + 8'(vecs[i].len);
    end

    // Redirect while the read of 0x07 is in flight
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    mem[8'h40] = 8'h60; mem[8'h41] = 8'h61; mem[8'h42] = 8'h62;
    do_reset();
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_addr == 8'h07) got = 1'b1;
    end
    check("rd07_timeout", got, 1);
    bus.redirect = 1'b1; bus.redirect_pc = 8'h40;
    @(negedge clk);
    bus.redirect = 1'b0;
    check("redir_valid0", bus.instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      get_instr(got, op, a1, a2, pc);
      check("redir_timeout", got, 1);
      check("redir_pc", pc, 8'h40 + 8'(i));
      check("redir_op", op, 8'h60 + 8'(i));
    end

    // Redirect and accept in the same cycle
    mem[8'h80] = 8'h2A; mem[8'h81] = 8'h2B;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.instr_valid) got = 1'b1;
    end
    check("rdacc_valid", got, 1);
    bus.redirect = 1'b1; bus.redirect_pc = 8'h80;
    @(negedge clk);
    bus.redirect = 1'b0;
    check("rdacc_valid0", bus.instr_valid, 0);
    check("rdacc_pc_now", bus.instr_pc, 8'h80);
    get_instr(got, op, a1, a2, pc);
    check("rdacc_timeout", got, 1);
    check("rdacc_pc", pc, 8'h80);
    check("rdacc_op", op, 8'h2A);
    get_instr(got, op, a1, a2, pc);
    check("rdacc_pc2", pc, 8'h81);
    check("rdacc_op2", op, 8'h2B);

    // goto spanning 0xFE, 0xFF, 0x00
    mem[8'hFE] = 8'hA7; mem[8'hFF] = 8'h00; mem[8'h00] = 8'h10; mem[8'h01] = 8'h05;
    @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_pc = 8'hFE;
    @(negedge clk);
    bus.redirect = 1'b0;
    get_instr(got, op, a1, a2, pc);
    check("wrap_timeout", got, 1);
    check("wrap_op", op, 8'hA7);
    check("wrap_arg1", a1, 8'h00);
    check("wrap_arg2", a2, 8'h10);
    check("wrap_pc", pc, 8'hFE);
    get_instr(got, op, a1, a2, pc);
    check("wrap_next_pc", pc, 8'h01);
    check("wrap_next_op", op, 8'h05);

    // sipush held with instr_ready low
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h01; mem[8'h02] = 8'h2C; mem[8'h03] = 8'h60;
    bus.instr_ready = 1'b0;
    do_reset();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.instr_valid) got = 1'b1;
    end
    check("stall_timeout", got, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", bus.instr_valid, 1);
      check("stall_op", bus.op_code, 8'h11);
      check("stall_arg1", bus.arg1, 8'h01);
      check("stall_arg2", bus.arg2, 8'h2C);
      check("stall_pc", bus.instr_pc, 8'h00);
    end
    check("stall_no_rd", bus.mem_rd, 0);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("stall_pc_adv", bus.instr_pc, 8'h03);
    check("stall_next_op", bus.op_code, 8'h60);

    // One-cycle reset mid-stream
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_valid", bus.instr_valid, 0);
    check("mrst_rd", bus.mem_rd, 0);
    check("mrst_op", bus.op_code, 0);
    @(negedge clk);
    check("mrst_rd1", bus.mem_rd, 1);
    check("mrst_addr", bus.mem_addr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
